// File: rtl/shreg_pkg.sv
// Shared types and frame-length helpers for the universal shift register.
package shreg_pkg;

    typedef enum logic [1:0] {
        SHREG_SL = 2'b00,
        SHREG_SR = 2'b01,
        SHREG_RL = 2'b10,
        SHREG_RR = 2'b11
    } shreg_mode_t;

    function automatic int unsigned frame_len(input int unsigned w, input int unsigned step);
        return w / step;
    endfunction

    // A two-shift frame still needs one counter bit.
    function automatic int unsigned frame_cnt_width(input int unsigned w, input int unsigned step);
        int unsigned len;
        len = frame_len(w, step);
        return (len > 2) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/shreg_frame_counter.sv
// Counts shifts within a frame and emits a registered one-cycle terminal-count pulse.
module shreg_frame_counter
    import shreg_pkg::*;
#(
    parameter int unsigned LEN = 4,
    parameter int unsigned CW  = 2
) (
    input  logic clk,
    input  logic sclr_n,
    input  logic clear,
    input  logic advance,
    output logic tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (advance) begin
            if (cnt == CW'(LEN - 1)) begin
                cnt <= '0;
                tc  <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
                tc  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: rtl/shreg_universal.sv
// Parametrised universal shift register with logical/rotate modes and STEP-bit lanes.
// Optional frame counter built when SHREG_FRAME_EN is defined.
module shreg_universal
    import shreg_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned STEP       = 1,
    parameter int unsigned SSET_VALUE = 2
) (
    input  logic            clk,
    input  logic            sclr_n,
    input  logic            sset,
    input  logic            en,
    input  logic            load,
    input  logic [1:0]      mode,
    input  logic [STEP-1:0] si,
    input  logic [W-1:0]    data,
    output logic [W-1:0]    q,
    output logic [STEP-1:0] so,
    output logic            frame_done
);

    if (W < 2 || STEP < 1 || STEP >= W || (W % STEP) != 0) begin : g_bad_params
        $error("shreg_universal: illegal W/STEP combination");
    end

    localparam logic [W-1:0] SSET_Q = W'(SSET_VALUE);

    shreg_mode_t       mode_e;
    logic [W-1:0]      shift_q;
    logic [STEP-1:0]   shift_so;

    assign mode_e = shreg_mode_t'(mode);

    always_comb begin
        shift_q  = q;
        shift_so = so;
        case (mode_e)
            SHREG_SL: begin
                shift_q  = {q[W-STEP-1:0], si};
                shift_so = q[W-1 -: STEP];
            end
            SHREG_SR: begin
                shift_q  = {si, q[W-1:STEP]};
                shift_so = q[STEP-1:0];
            end
            SHREG_RL: begin
                shift_q  = {q[W-STEP-1:0], q[W-1 -: STEP]};
                shift_so = q[W-1 -: STEP];
            end
            SHREG_RR: begin
                shift_q  = {q[STEP-1:0], q[W-1:STEP]};
                shift_so = q[STEP-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            q  <= '0;
            so <= '0;
        end else if (sset) begin
            q <= SSET_Q;
        end else if (en) begin
            if (load) begin
                q <= data;
            end else begin
                q  <= shift_q;
                so <= shift_so;
            end
        end
    end

`ifdef SHREG_FRAME_EN
    localparam int unsigned FRAME_LEN = frame_len(W, STEP);
    localparam int unsigned CNT_W     = frame_cnt_width(W, STEP);

    logic frame_clear;
    logic frame_advance;

    // sset outranks en, so it restarts the frame even while disabled.
    assign frame_clear   = sset | (en & load);
    assign frame_advance = en & ~load & ~sset;

    shreg_frame_counter #(
        .LEN (FRAME_LEN),
        .CW  (CNT_W)
    ) u_frame_counter (
        .clk     (clk),
        .sclr_n  (sclr_n),
        .clear   (frame_clear),
        .advance (frame_advance),
        .tc      (frame_done)
    );
`else
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_shreg_universal.sv
// Directed self-checking bench for shreg_universal (W=8/STEP=2 and W=4/STEP=1 instances).
module tb_shreg_universal;

`ifdef SHREG_FRAME_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sclr_n, sset, en, load;
    logic [1:0] mode;
    logic [1:0] si;
    logic [7:0] data;
    logic [7:0] q;
    logic [1:0] so;
    logic       fd;

    logic       si2;
    logic [3:0] data2;
    logic [3:0] q2;
    logic       so2;
    logic       fd2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shreg_universal #(.W(8), .STEP(2), .SSET_VALUE(2)) dut (
        .clk(clk), .sclr_n(sclr_n), .sset(sset), .en(en), .load(load), .mode(mode),
        .si(si), .data(data), .q(q), .so(so), .frame_done(fd)
    );

    shreg_universal #(.W(4), .STEP(1), .SSET_VALUE(2)) dut_small (
        .clk(clk), .sclr_n(sclr_n), .sset(sset), .en(en), .load(load), .mode(mode),
        .si(si2), .data(data2), .q(q2), .so(so2), .frame_done(fd2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sclr_n = 1'b0; sset = 1'b1; load = 1'b1; en = 1'b1;
        data = 8'hFF; mode = 2'b00; si = 2'b11; si2 = 1'b1; data2 = 4'hF;
        tick();
        tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h exp 00", q); end
        tests++; if (so !== 2'b00) begin fails++; $display("FAIL reset_so got %b exp 00", so); end
        tests++; if (fd !== 1'b0) begin fails++; $display("FAIL reset_fd got %b exp 0", fd); end
        tests++; if (q2 !== 4'h0) begin fails++; $display("FAIL reset_q2 got %h exp 0", q2); end
        tests++; if (fd2 !== 1'b0) begin fails++; $display("FAIL reset_fd2 got %b exp 0", fd2); end
        sclr_n = 1'b1; sset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_modes();
        logic [1:0] md  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] sis [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        logic [7:0] eq  [4] = '{8'h97, 8'h69, 8'h96, 8'h69};
        logic [1:0] eso [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; load = 1'b1; data = 8'hA5;
            tick();
            load = 1'b0; mode = md[i]; si = sis[i];
            tick();
            tests++; if (q !== eq[i]) begin fails++; $display("FAIL mode%0d_q got %h exp %h", i, q, eq[i]); end
            tests++; if (so !== eso[i]) begin fails++; $display("FAIL mode%0d_so got %b exp %b", i, so, eso[i]); end
            tests++; if (fd !== 1'b0) begin fails++; $display("FAIL mode%0d_fd got %b exp 0", i, fd); end
        end
        en = 1'b0;
    endtask

    task automatic test_priority();
        sset = 1'b1; en = 1'b1; load = 1'b1; data = 8'hFF;
        tick();
        tests++; if (q !== 8'h02) begin fails++; $display("FAIL prio_sset_q got %h exp 02", q); end
        tests++; if (so !== 2'b01) begin fails++; $display("FAIL prio_sset_so got %b exp 01", so); end
        sset = 1'b0; en = 1'b0; load = 1'b1;
        tick();
        tests++; if (q !== 8'h02) begin fails++; $display("FAIL prio_en_q got %h exp 02", q); end
        tests++; if (so !== 2'b01) begin fails++; $display("FAIL prio_en_so got %b exp 01", so); end
        tests++; if (fd !== 1'b0) begin fails++; $display("FAIL prio_en_fd got %b exp 0", fd); end
        load = 1'b0;
    endtask

    task automatic test_frame();
        logic [7:0] eq  [8] = '{8'h0C, 8'h30, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [1:0] eso [8] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        logic       efd;
        en = 1'b1; load = 1'b1; data = 8'hC3;
        tick();
        tests++; if (q !== 8'hC3) begin fails++; $display("FAIL frame_load_q got %h exp c3", q); end
        load = 1'b0; mode = 2'b00; si = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            efd = FE && (i == 3 || i == 7);
            tests++; if (q !== eq[i]) begin fails++; $display("FAIL frame%0d_q got %h exp %h", i, q, eq[i]); end
            tests++; if (so !== eso[i]) begin fails++; $display("FAIL frame%0d_so got %b exp %b", i, so, eso[i]); end
            tests++; if (fd !== efd) begin fails++; $display("FAIL frame%0d_fd got %b exp %b", i, fd, efd); end
        end
        en = 1'b0;
    endtask

    // op codes: 0 shift, 1 en low, 2 load, 3 sync clear
    task automatic test_frame_interrupt();
        int unsigned ops [21] = '{0,0,1,1,1,0,0, 0,0,2,0,0,0,0, 0,0,3,0,0,0,0};
        logic        efd;
        en = 1'b1; load = 1'b1; data = 8'h00; mode = 2'b00; si = 2'b00;
        tick();
        for (int i = 0; i < 21; i++) begin
            sclr_n = (ops[i] != 3);
            en     = (ops[i] != 1);
            load   = (ops[i] == 2);
            tick();
            efd = FE && (i == 6 || i == 13 || i == 20);
            tests++; if (fd !== efd) begin fails++; $display("FAIL intr%0d_fd got %b exp %b", i, fd, efd); end
        end
        sclr_n = 1'b1; en = 1'b0; load = 1'b0;
    endtask

    task automatic test_small();
        en = 1'b1; load = 1'b1; data2 = 4'b1001; si2 = 1'b0;
        tick();
        tests++; if (q2 !== 4'b1001) begin fails++; $display("FAIL small_load_q got %b exp 1001", q2); end
        load = 1'b0; mode = 2'b01; si2 = 1'b1;
        tick();
        tests++; if (q2 !== 4'b1100) begin fails++; $display("FAIL small_sr_q got %b exp 1100", q2); end
        tests++; if (so2 !== 1'b1) begin fails++; $display("FAIL small_sr_so got %b exp 1", so2); end
        tests++; if (fd2 !== 1'b0) begin fails++; $display("FAIL small_sr_fd got %b exp 0", fd2); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_priority();
        test_frame();
        test_frame_interrupt();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
